// File: rtl/unshift.sv
// Parallel-in, serial-out transmit shifter: loads a word when idle and emits one bit per i_en strobe.
// Define UNSHIFT_MSB_FIRST_EN to send the MSB first (default sends the LSB first).
module unshift #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_en,
  output logic             o_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int INDEX = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [INDEX-1:0] LAST = INDEX'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [INDEX-1:0] cnt;
  logic [WIDTH-1:0] sr_next;
  logic             sr_out;

`ifdef UNSHIFT_MSB_FIRST_EN
  assign sr_out  = sr[WIDTH-1];
  assign sr_next = sr << 1;
`else
  assign sr_out  = sr[0];
  assign sr_next = sr >> 1;
`endif

  // Outputs depend on registers only, so the receiver never sees an input-to-output path.
  assign o_busy = (state == ST_SEND);
  assign o_data = (state == ST_SEND) ? sr_out : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      sr     <= '0;
      cnt    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // An i_en coinciding with the load is ignored: no bit was on the wire yet.
          if (i_load) begin
            sr    <= i_word;
            cnt   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_en) begin
            if (cnt == LAST) begin
              state  <= ST_IDLE;
              sr     <= '0;
              cnt    <= '0;
              o_done <= 1'b1;
            end else begin
              sr  <= sr_next;
              cnt <= cnt + INDEX'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unshift.sv
// Directed, table-driven bench for unshift (WIDTH=8 main instance plus a WIDTH=1 instance).
// Expected bit orders follow UNSHIFT_MSB_FIRST_EN when it is defined for the build.
module tb_unshift;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] word;
  logic       en;
  logic       data;
  logic       busy;
  logic       done;

  logic       u1_load;
  logic [0:0] u1_word;
  logic       u1_en;
  logic       u1_data;
  logic       u1_busy;
  logic       u1_done;

  int total = 0;
  int bad   = 0;

`ifdef UNSHIFT_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  unshift #(.WIDTH(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (load),
    .i_word (word),
    .i_en   (en),
    .o_data (data),
    .o_busy (busy),
    .o_done (done)
  );

  unshift #(.WIDTH(1)) dut_w1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (u1_load),
    .i_word (u1_word),
    .i_en   (u1_en),
    .o_data (u1_data),
    .o_busy (u1_busy),
    .o_done (u1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_lsb / exp_msb: bit i is the i-th transmitted bit, hand-computed for each order.
  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
    logic [7:0] gaps;
    logic       en_on_load;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] pick(input logic [7:0] lsb, input logic [7:0] msb);
    return MSB_FIRST ? msb : lsb;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic [7:0] w, input logic e);
    load = l;
    word = w;
    en   = e;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loads a word, clocks out all 8 bits with optional idle gaps, and ends in the o_done cycle.
  task automatic sendWord(input logic [7:0] w, input logic [7:0] exp, input logic [7:0] gaps,
                          input logic en_on_load, input string tag);
    logic [7:0] rx;
    rx = '0;
    applyStimulus(1'b1, w, en_on_load);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput({tag, "_busy_after_load"}, {7'd0, busy}, 8'd1);
    checkOutput({tag, "_nodone_after_load"}, {7'd0, done}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        applyStimulus(1'b0, 8'h00, 1'b0);
        step();
        checkOutput($sformatf("%s_gap_busy%0d", tag, i), {7'd0, busy}, 8'd1);
      end
      checkOutput($sformatf("%s_bit%0d", tag, i), {7'd0, data}, {7'd0, exp[i]});
      if (MSB_FIRST) rx[7-i] = data;
      else           rx[i]   = data;
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput({tag, "_busy_end"}, {7'd0, busy}, 8'd0);
    checkOutput({tag, "_done_pulse"}, {7'd0, done}, 8'd1);
    checkOutput({tag, "_data_idle"}, {7'd0, data}, 8'd0);
    checkOutput({tag, "_rx_word"}, rx, w);
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5, gaps: 8'h00,        en_on_load: 1'b0};
    vecs[1] = '{word: 8'h3C, exp_lsb: 8'h3C, exp_msb: 8'h3C, gaps: 8'b10110100,  en_on_load: 1'b0};
    vecs[2] = '{word: 8'h96, exp_lsb: 8'h96, exp_msb: 8'h69, gaps: 8'h00,        en_on_load: 1'b0};
    vecs[3] = '{word: 8'h0F, exp_lsb: 8'h0F, exp_msb: 8'hF0, gaps: 8'b00000011,  en_on_load: 1'b0};
    vecs[4] = '{word: 8'h02, exp_lsb: 8'h02, exp_msb: 8'h40, gaps: 8'h00,        en_on_load: 1'b1};
    vecs[5] = '{word: 8'hFF, exp_lsb: 8'hFF, exp_msb: 8'hFF, gaps: 8'b01000001,  en_on_load: 1'b0};

    rst = 1'b1;
    applyStimulus(1'b1, 8'hFF, 1'b1);
    u1_load = 1'b0;
    u1_word = 1'b0;
    u1_en   = 1'b0;
    step();
    step();
    checkOutput("reset_busy", {7'd0, busy}, 8'd0);
    checkOutput("reset_data", {7'd0, data}, 8'd0);
    checkOutput("reset_done", {7'd0, done}, 8'd0);
    checkOutput("reset_w1_busy", {7'd0, u1_busy}, 8'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    checkOutput("idle_en_no_busy", {7'd0, busy}, 8'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    foreach (vecs[k]) begin
      sendWord(vecs[k].word, pick(vecs[k].exp_lsb, vecs[k].exp_msb), vecs[k].gaps,
               vecs[k].en_on_load, $sformatf("vec%0d", k));
      step();
      checkOutput($sformatf("vec%0d_done_one_cycle", k), {7'd0, done}, 8'd0);
    end

    // Back-to-back: second load is issued in the o_done cycle and must be accepted.
    sendWord(8'h02, pick(8'h02, 8'h40), 8'h00, 1'b1, "b2b_first");
    sendWord(8'h96, pick(8'h96, 8'h69), 8'h00, 1'b0, "b2b_second");
    step();
    checkOutput("b2b_done_clear", {7'd0, done}, 8'd0);

    // Load while busy: the 0x00 word must be dropped.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        applyStimulus(1'b1, 8'h00, 1'b0);
        step();
        checkOutput("lwb_busy_after_ignored_load", {7'd0, busy}, 8'd1);
      end
      checkOutput($sformatf("lwb_bit%0d", i), {7'd0, data}, 8'd1);
      checkOutput($sformatf("lwb_nodone%0d", i), {7'd0, done}, 8'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lwb_done", {7'd0, done}, 8'd1);
    checkOutput("lwb_busy_end", {7'd0, busy}, 8'd0);
    step();

    // Mid-word reset: abandon 0x81 after 4 bits, no done afterwards.
    applyStimulus(1'b1, 8'h81, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mrst_bit%0d", i), {7'd0, data}, (i == 0) ? 8'd1 : 8'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();
    end
    rst = 1'b1;
    applyStimulus(1'b1, 8'hFF, 1'b1);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("mrst_busy", {7'd0, busy}, 8'd0);
    checkOutput("mrst_data", {7'd0, data}, 8'd0);
    checkOutput("mrst_done", {7'd0, done}, 8'd0);
    step();
    checkOutput("mrst_done_later", {7'd0, done}, 8'd0);
    sendWord(8'h01, pick(8'h01, 8'h80), 8'h00, 1'b0, "after_rst");
    step();

    // WIDTH=1 instance: a single enable completes the word.
    u1_load = 1'b1;
    u1_word = 1'b1;
    step();
    u1_load = 1'b0;
    checkOutput("w1_busy", {7'd0, u1_busy}, 8'd1);
    checkOutput("w1_data", {7'd0, u1_data}, 8'd1);
    u1_en = 1'b1;
    step();
    u1_en = 1'b0;
    checkOutput("w1_done", {7'd0, u1_done}, 8'd1);
    checkOutput("w1_busy_end", {7'd0, u1_busy}, 8'd0);
    step();
    checkOutput("w1_done_clear", {7'd0, u1_done}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unshift.md
# unshift

Parallel-in, serial-out shift register: the transmit end of the serial bit-stream link whose receiver assembles `WIDTH`-bit words one bit per enabled clock. The block accepts a parallel word, presents it one bit at a time on `o_data`, and advances on each `i_en` strobe. With default configuration it sends LSB first, so bit 0 leaves first. One `i_en` line can drive both ends, so a full word moves in exactly `WIDTH` enabled cycles.

## Interface
- `WIDTH`, default 8: word width in bits, legal range ≥ 1.
- `INDEX` (localparam): `$clog2(WIDTH)` when `WIDTH` > 1, else 1; width of the bit counter.
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst`  input  1  reset; synchronous, active-high, sampled on the `i_clk` rising edge.
- `i_load`  input  1  load strobe; captures `i_word` when the block is idle.
- `i_word`  input  `WIDTH`  parallel word to transmit.
- `i_en`  input  1  shift strobe shared with the receiver; the current bit is consumed on each enabled cycle.
- `o_data`  output  1  current serial bit; valid while `o_busy`=1, 0 otherwise.
- `o_busy`  output  1  high from the cycle after an accepted load until the last bit is consumed.
- `o_done`  output  1  one-cycle pulse in the cycle after the last bit is consumed.

## Operation
- State machine has two states:
  - IDLE: `o_busy`=0.
  - SEND: `o_busy`=1.
- Internal registers: shift register `sr[WIDTH-1:0]` and counter `cnt[INDEX-1:0]`.
- IDLE with `i_load`=1: `sr`←`i_word`, `cnt`←0, go to SEND. Any `i_en` in the same cycle is ignored, because no bit was presented yet.
- IDLE with `i_load`=0: hold. `o_data`=0.
- SEND output: `o_data`=`sr[0]` (LSB-first build).
- SEND with `i_en`=1 and `cnt`<`WIDTH`-1: `sr`←`sr>>1`, `cnt`←`cnt`+1.
- SEND with `i_en`=1 and `cnt`=`WIDTH`-1: go to IDLE, `sr`←0, `cnt`←0, `o_done`←1 for the next cycle only.
- SEND with `i_en`=0: hold. `o_data` is stable.
- `i_load` during SEND is ignored. The word is dropped, with no queueing. The upstream must wait for `o_busy`=0.
- `i_load` in the same cycle `o_done` is high is accepted, because the state is already IDLE. Back-to-back words therefore have one idle cycle between them.
- `WIDTH`=1: the first `i_en` in SEND completes the word. The counter never increments.
- `cnt` never exceeds `WIDTH`-1, and there is no wrap-around. `i_en` in IDLE has no effect.

## Timing
- Reset values: `o_data`=0, `o_busy`=0, `o_done`=0, `sr`=0, `cnt`=0, state IDLE.
- Reset priority: `i_rst` overrides `i_load` and `i_en` in the same cycle. Reset mid-word abandons the word, and no `o_done` is generated.
- Load latency: `i_load` at edge N gives `o_busy`=1 and `o_data`=bit 0 from N+1.
- Per bit: the bit is presented combinationally from `sr`. The receiver samples it on the same edge where `i_en`=1, and the next bit appears after that edge.
- Word time: with `i_en` held high from the cycle after load, the last bit is consumed at edge N+`WIDTH`. `o_busy` falls and `o_done`=1 from N+`WIDTH`+1 through N+`WIDTH`+1 inclusive, i.e. one cycle.
- `o_busy`, `o_done` and the state are registered. `o_data` is a mux of registers only, with no input-to-output combinational path.

## Configuration
- `UNSHIFT_MSB_FIRST_EN` undefined (default): LSB first. `o_data`=`sr[0]`, shift right. Bit order matches the receiver, which fills index 0 first.
- `UNSHIFT_MSB_FIRST_EN` defined: MSB first. `o_data`=`sr[WIDTH-1]`, shift left. Counter, handshake and timing are unchanged.

## Test plan
- Basic transfer: `WIDTH`=8, load 0xA5, then `i_en`=1 for 8 cycles -> `o_data` sequence 1,0,1,0,0,1,0,1. `o_busy` high for 8 cycles, then `o_done` pulses once.
- Loopback: drive the receiver from `o_data` with the same `i_en` and random gaps in `i_en`. Load 0x3C -> receiver word = 0x3C after 8 enabled cycles. `o_done` appears in the cycle after the last enable.
- Load while busy: load 0xFF, then pulse `i_load` with 0x00 after 3 bits -> the remaining bits are still 1s. `o_done` appears after 8 enables total.
- Mid-word reset: load 0x81, consume 4 bits, assert `i_rst` -> next cycle `o_busy`=0, `o_data`=0, `o_done`=0. A new load of 0x01 then sends 1,0,0,0,0,0,0,0.
- Simultaneous load and enable in IDLE, plus back-to-back: `i_load` and `i_en` both high with 0x02 -> the first enabled bit is 0, not skipped. A second load asserted with `o_done` is accepted.
- Edge widths and macro: `WIDTH`=1, load 1 -> one enable completes and `o_done` pulses. With `UNSHIFT_MSB_FIRST_EN`, 0xA5 -> sequence 1,0,1,0,0,1,0,1 in MSB order (bits 7..0).
